// File: rtl/exe_stage_pkg.sv
// Shared datapath sizes, ALU opcode encodings and the single-cycle ALU function
// used by the execute stage.
package exe_stage_pkg;

    localparam int unsigned DSIZE = 16;
    localparam int unsigned ASIZE = 5;
    localparam int unsigned SHW   = $clog2(DSIZE);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_MUL = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mul_state_e;

    // MUL is not handled here; it yields zero and is resolved by the multiplier.
    function automatic logic [DSIZE-1:0] alu_calc(input logic [2:0]       op,
                                                  input logic [DSIZE-1:0] a,
                                                  input logic [DSIZE-1:0] b);
        logic [DSIZE-1:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[SHW-1:0];
            ALU_SRL: r = a >> b[SHW-1:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one load cycle, DSIZE add/shift steps, one
// result cycle. Returns the low DSIZE bits of the unsigned product.
module mul_seq
    import exe_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [DSIZE-1:0] product
);

    localparam logic [SHW-1:0] CntLast = SHW'(DSIZE - 1);

    mul_state_e       state_q;
    logic [SHW-1:0]   cnt_q;
    logic [DSIZE-1:0] acc_q;
    logic [DSIZE-1:0] mcand_q;
    logic [DSIZE-1:0] mplier_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + SHW'(1);
                        if (cnt_q == CntLast) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = (state_q == StBusy);
    assign done    = (state_q == StDone);
    assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: combinational single-cycle ALU plus an iterative multiplier
// that stalls upstream until its product is ready.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [2:0]       aluop,
    input  logic [DSIZE-1:0] rdata1,
    input  logic [DSIZE-1:0] rdata2,
    input  logic [DSIZE-1:0] imm,
    input  logic             sel_imm,
    input  logic [ASIZE-1:0] waddr_in,
    output logic [DSIZE-1:0] alu_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             stall
);

    logic             is_mul;
    logic [DSIZE-1:0] op_b;
    logic             mul_busy;
    logic             mul_done;
    logic [DSIZE-1:0] mul_product;

    assign is_mul = valid_in && (aluop == ALU_MUL);
    assign op_b   = sel_imm ? imm : rdata2;

    mul_seq u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (is_mul),
        .abort   (!is_mul),
        .a       (rdata1),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // While the multiplier is mid-operation anything but the held MUL is a
    // protocol violation: emit a bubble and let the multiplier abort.
    always_comb begin
        alu_out   = '0;
        waddr_out = '0;
        stall     = 1'b0;
        if (!rst) begin
            if (mul_busy || mul_done) begin
                if (is_mul) begin
                    stall = mul_busy;
                    if (mul_done) begin
                        alu_out   = mul_product;
                        waddr_out = waddr_in;
                    end
                end
            end else if (valid_in) begin
                if (is_mul) begin
                    stall = 1'b1;
                end else begin
                    alu_out   = alu_calc(aluop, rdata1, op_b);
                    waddr_out = waddr_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: the driver pushes expected results, a
// negedge monitor pops and compares whenever a non-bubble result appears.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  aluop;
    logic [15:0] rdata1;
    logic [15:0] rdata2;
    logic [15:0] imm;
    logic        sel_imm;
    logic [4:0]  waddr_in;
    logic [15:0] alu_out;
    logic [4:0]  waddr_out;
    logic        stall;

    int vectors = 0;
    int miscompares = 0;
    logic [20:0] exp_q[$];

    always #5 clk = ~clk;

    exe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .aluop     (aluop),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .imm       (imm),
        .sel_imm   (sel_imm),
        .waddr_in  (waddr_in),
        .alu_out   (alu_out),
        .waddr_out (waddr_out),
        .stall     (stall)
    );

    // Reference ALU from plain integer arithmetic.
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned sh = ub % 16;
        int unsigned r;
        case (op)
            3'd0:    r = ua + ub;
            3'd1:    r = ua - ub;
            3'd2:    r = ua & ub;
            3'd3:    r = ua | ub;
            3'd4:    r = ua ^ ub;
            3'd5:    r = ua << sh;
            3'd6:    r = ua >> sh;
            default: r = ua * ub;
        endcase
        return 16'(r);
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every non-bubble output must match the oldest pending result.
    always @(negedge clk) begin
        if (waddr_out != 5'd0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got alu_out=0x%0h waddr_out=%0d, expected none",
                         alu_out, waddr_out);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                if ({alu_out, waddr_out} != e) begin
                    miscompares++;
                    $display("FAIL result: got alu_out=0x%0h waddr_out=%0d, expected 0x%0h/%0d",
                             alu_out, waddr_out, e[20:5], e[4:0]);
                end
            end
        end
    end

    // Upstream behaviour: hold the instruction while stall is high.
    task automatic wait_accept(input int exp_n, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 40) break;
        end
        check(name, n, exp_n);
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] im, input logic sel, input logic [4:0] wa);
        logic [15:0] bop;
        aluop    = op;
        rdata1   = a;
        rdata2   = b;
        imm      = im;
        sel_imm  = sel;
        waddr_in = wa;
        valid_in = 1'b1;
        bop      = sel ? im : b;
        exp_q.push_back({ref_alu(op, a, bop), wa});
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] im, input logic sel, input logic [4:0] wa);
        present(op, a, b, im, sel, wa);
        wait_accept((op == 3'd7) ? 17 : 0, "stall_len");
    endtask

    task automatic idle_cycle();
        valid_in = 1'b0;
        @(negedge clk);
        check("idle_stall", int'(stall), 0);
        check("idle_waddr", int'(waddr_out), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b1;
        aluop = 3'd0;
        rdata1 = 16'h1234;
        rdata2 = 16'h0001;
        imm = 16'h0;
        sel_imm = 1'b0;
        waddr_in = 5'd9;

        @(negedge clk);
        check("rst_alu_out", int'(alu_out), 0);
        check("rst_waddr", int'(waddr_out), 0);
        check("rst_stall", int'(stall), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();

        // Directed vectors
        issue(3'd0, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 5'd3);
        issue(3'd5, 16'h0001, 16'h0000, 16'h0013, 1'b1, 5'd4);
        issue(3'd6, 16'h8000, 16'h000F, 16'h0000, 1'b0, 5'd5);
        issue(3'd7, 16'h0012, 16'h0034, 16'h0000, 1'b0, 5'd7);
        issue(3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 5'd8);
        issue(3'd0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 5'd9);

        // Reset during BUSY with cnt=5; the MUL then restarts from its load cycle.
        present(3'd7, 16'h0123, 16'h0045, 16'h0000, 1'b0, 5'd10);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", int'(stall), 0);
        check("midrst_waddr", int'(waddr_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_accept(17, "post_rst_stall_len");

        // Drop valid_in during BUSY: next cycle is a bubble and the FSM is idle.
        aluop = 3'd7;
        rdata1 = 16'h0077;
        rdata2 = 16'h0011;
        sel_imm = 1'b0;
        waddr_in = 5'd11;
        valid_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        idle_cycle();
        issue(3'd7, 16'h00AB, 16'h0003, 16'h0000, 1'b0, 5'd12);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            issue(op, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                  5'($urandom_range(1, 31)));
            if ($urandom_range(0, 5) == 0) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        check("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage teaching pipeline. It sits between the ID/EXE register and the EXE/WB register, and drives that register's alu_in and waddr_in inputs. Single-cycle ALU ops resolve combinationally in one cycle. MUL runs on an iterative shift-add FSM that stalls the upstream stages until the product is ready.

Parameters:
DSIZE, 16, datapath width in bits (matches shared define)
ASIZE, 5, register-address width (matches shared define)
SHW, 4, shift-amount width, log2(DSIZE), derived localparam

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_in  in  1  ID/EXE holds a valid instruction
aluop  in  3  operation select
rdata1  in  DSIZE  operand A from register file
rdata2  in  DSIZE  operand B from register file
imm  in  DSIZE  pre-extended immediate
sel_imm  in  1  1: operand B = imm; 0: operand B = rdata2
waddr_in  in  ASIZE  destination register
alu_out  out  DSIZE  result to EXE/WB alu_in
waddr_out  out  ASIZE  destination to EXE/WB waddr_in; 0 = bubble (r0 writes are discarded)
stall  out  1  upstream holds PC, IF/ID and ID/EXE while high

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - rst sets state=IDLE and clears cnt, acc, mcand and mplier.
  - While rst is high, all outputs are forced: alu_out=0, waddr_out=0, stall=0.
- aluop encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- Operand selection: B = sel_imm ? imm : rdata2.
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^DSIZE. No flags are produced.
  - SLL and SRL shift A by B[SHW-1:0]. SRL is a logical shift with zero fill.
  - MUL returns the low DSIZE bits of A*B (unsigned).
- Non-MUL op with valid_in=1: combinational result. alu_out = result, waddr_out = waddr_in, stall=0. Zero added latency; EXE/WB captures the result on the next edge.
- valid_in=0: alu_out=0, waddr_out=0, stall=0. The FSM returns to or stays in IDLE.
- MUL FSM, with states IDLE, BUSY, DONE:
  - IDLE, on valid MUL: latch mcand=A, mplier=B, acc=0, cnt=0; go to BUSY. Outputs: stall=1, bubble.
  - BUSY, each cycle:
    - If mplier[0]=1, acc += mcand.
    - mcand <<= 1, mplier >>= 1, cnt++.
    - When cnt==DSIZE-1 on this step, go to DONE.
    - Outputs: stall=1, bubble.
  - DONE: alu_out = acc, waddr_out = waddr_in, stall=0; go to IDLE. Upstream advances on this edge.
  - The upstream-held instruction is visible for DSIZE+2 cycles in total (18 cycles at DSIZE=16).
- Protocol violation: if valid_in drops or aluop leaves MUL while in BUSY or DONE, abort to IDLE at the next edge. Outputs a bubble with stall=0 that cycle; acc is discarded.
- Back-to-back MULs: the DONE→IDLE edge accepts the next instruction. A second MUL starts its own IDLE load cycle; there is no overlap.
- Reset mid-MUL: on the next edge the FSM is in IDLE and the partial product is lost. If the MUL is still presented afterwards, it restarts from the load cycle.
- Operand changes during BUSY are ignored, because operands were latched at load.

Decomposition:
- The aluop encodings (ALU_ADD … ALU_MUL) and the DSIZE/ASIZE/SHW defines belong in the shared define.v.
- One sub-module, mul_seq, holds the iterative multiplier and its FSM.
  - Interface: clk, rst, start, abort, a, b → busy, done, product.
- exe_stage instantiates mul_seq, plus the combinational ALU mux and the bubble/stall logic.

Test Plan:
- ADD: A=0xFFFF, B=0x0002, sel_imm=0, waddr_in=3 → same cycle alu_out=0x0001, waddr_out=3, stall=0. EXE/WB shows 0x0001 after 1 edge.
- Immediate and shifts:
  - SLL with sel_imm=1, A=0x0001, imm=0x0013 → alu_out=0x0008 (uses B[3:0]=3).
  - SRL with A=0x8000, B=15 → alu_out=0x0001.
- MUL: A=0x0012, B=0x0034, waddr_in=7, upstream holds while stall=1.
  - stall high for exactly 17 cycles with waddr_out=0 throughout.
  - 18th cycle: alu_out=0x03A8, waddr_out=7, stall=0.
- MUL overflow: A=0xFFFF, B=0xFFFF → alu_out=0x0001 at DONE. Immediately follow with ADD 1+1 → 0x0002 in the next cycle, stall=0.
- Reset mid-MUL: assert rst for 1 cycle at BUSY cnt=5.
  - During rst: stall=0, waddr_out=0.
  - After rst, MUL still presented: full 18-cycle sequence and the correct product.
- valid_in=0, and valid_in dropped during BUSY → waddr_out=0, stall=0 next cycle, FSM back in IDLE.
